l1_dcache: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache on the CPU data port.
//  - CPU side: 32-bit word port with byte mask.
//  - Memory side: 256-bit line port toward the memory arbiter / physical memory.
//  - Request/response contract matches the pipeline memory access proxy: request held

---
 rtl/l1_dcache_pkg.sv | 19 +
 rtl/l1_dcache_if.sv | 36 +++
 rtl/l1_dcache_data_array.sv | 25 ++
 rtl/l1_dcache.sv | 143 ++++++++++++++
 tb/tb_l1_dcache.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_dcache_pkg.sv
// Shared types for the L1 data cache: FSM states, line type, offset width.
// Also a helper that expands a CPU word byte mask into line byte enables.
package cache_types;

  localparam int OFFSET_W = 5;

  typedef logic [255:0] cache_line_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH
  } dcache_state_t;

  function automatic logic [31:0] line_byte_we(input logic [2:0] word, input logic [3:0] wmask);
    return {28'b0, wmask} << {word, 2'b00};
  endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// CPU word port (request held until the one-cycle resp pulse) and 256-bit line port
// toward memory (read/write held until the resp pulse); master drives the request.
interface l1_dcache_cpu_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_read;
  logic              cpu_write;
  logic [3:0]        cpu_wmask;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_resp;

  modport master (output cpu_read, cpu_write, cpu_wmask, cpu_addr, cpu_wdata,
                  input  cpu_rdata, cpu_resp);
  modport slave  (input  cpu_read, cpu_write, cpu_wmask, cpu_addr, cpu_wdata,
                  output cpu_rdata, cpu_resp);
endinterface

interface l1_dcache_mem_if #(
  parameter int ADDR_W = 32
);
  import cache_types::*;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  cache_line_t       pmem_wdata;
  cache_line_t       pmem_rdata;
  logic              pmem_resp;

  modport master (output pmem_read, pmem_write, pmem_addr, pmem_wdata,
                  input  pmem_rdata, pmem_resp);
  modport slave  (input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
                  output pmem_rdata, pmem_resp);
endinterface

// File: rtl/l1_dcache_data_array.sv
// Line storage: NUM_SETS x 256 bits, combinational read, per-byte write enables.
// Zero-latency read; one-cycle write; no handshake, no reset (contents are don't-care until filled).
module cache_data_array
  import cache_types::*;
#(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic [S_INDEX-1:0] index,
  input  logic [31:0]        byte_we,
  input  cache_line_t        wdata,
  output cache_line_t        rdata
);

  cache_line_t lines [2**S_INDEX];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 32; b++) begin
      if (byte_we[b]) lines[index][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = lines[index];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 D-cache; hit 1 cycle, miss = mem latency + 2 (+ writeback).
// CPU request held until cpu_resp pulse; stalls on memory via pmem_resp. Perf counters under DCACHE_PERF_CNT_EN.
module l1_dcache
  import cache_types::*;
#(
  parameter int S_INDEX = 4,
  parameter int ADDR_W  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  l1_dcache_cpu_if.slave  cpu,
  l1_dcache_mem_if.master pmem,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
);

  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int TAG_W    = ADDR_W - OFFSET_W - S_INDEX;

  dcache_state_t       state, state_nxt;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  logic [NUM_SETS-1:0] valid, dirty;
  logic [TAG_W-1:0]    req_tag;
  logic [S_INDEX-1:0]  index;
  logic [2:0]          word;
  logic                req, hit, hit_done, miss_go, fill;
  logic [31:0]         byte_we;
  cache_line_t         line_rd, line_wr;
  logic                unused_addr_bits;

  assign req_tag          = cpu.cpu_addr[ADDR_W-1 -: TAG_W];
  assign index            = cpu.cpu_addr[OFFSET_W +: S_INDEX];
  assign word             = cpu.cpu_addr[4:2];
  assign unused_addr_bits = ^cpu.cpu_addr[1:0];

  // A request seen during the resp cycle is the one just completed, not a new one.
  assign req = (cpu.cpu_read | cpu.cpu_write) & ~cpu.cpu_resp;
  assign hit = valid[index] && (tags[index] == req_tag);

  always_comb begin
    state_nxt       = state;
    hit_done        = 1'b0;
    miss_go         = 1'b0;
    fill            = 1'b0;
    pmem.pmem_read  = 1'b0;
    pmem.pmem_write = 1'b0;
    pmem.pmem_addr  = '0;
    pmem.pmem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            hit_done = 1'b1;
          end else begin
            miss_go   = 1'b1;
            state_nxt = (valid[index] && dirty[index]) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        pmem.pmem_write = 1'b1;
        pmem.pmem_addr  = {tags[index], index, {OFFSET_W{1'b0}}};
        pmem.pmem_wdata = line_rd;
        if (pmem.pmem_resp) state_nxt = FETCH;
      end
      FETCH: begin
        pmem.pmem_read = 1'b1;
        pmem.pmem_addr = {req_tag, index, {OFFSET_W{1'b0}}};
        if (pmem.pmem_resp) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_we = '0;
    line_wr = {8{cpu.cpu_wdata}};
    if (fill) begin
      byte_we = '1;
      line_wr = pmem.pmem_rdata;
    end else if (hit_done && cpu.cpu_write) begin
      byte_we = line_byte_we(word, cpu.cpu_wmask);
    end
  end

  cache_data_array #(.S_INDEX(S_INDEX)) u_data (
    .clk     (clk),
    .index   (index),
    .byte_we (byte_we),
    .wdata   (line_wr),
    .rdata   (line_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      for (int i = 0; i < NUM_SETS; i++) tags[i] <= '0;
      cpu.cpu_resp  <= 1'b0;
      cpu.cpu_rdata <= '0;
    end else begin
      state        <= state_nxt;
      cpu.cpu_resp <= hit_done;
      if (hit_done && !cpu.cpu_write) cpu.cpu_rdata <= line_rd[{word, 5'b00000} +: 32];
      if (hit_done && cpu.cpu_write && (cpu.cpu_wmask != 4'b0000)) dirty[index] <= 1'b1;
      if (fill) begin
        tags[index]  <= req_tag;
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // A hit that completes a request which already missed is not counted again.
  logic missed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      missed   <= 1'b0;
    end else begin
      if (miss_go) begin
        miss_cnt <= miss_cnt + 32'd1;
        missed   <= 1'b1;
      end
      if (hit_done) begin
        if (!missed) hit_cnt <= hit_cnt + 32'd1;
        missed <= 1'b0;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Randomised bench for l1_dcache: cache + memory model compared against a flat word memory,
// plus a direct-mapped presence model predicting hit/miss/writeback traffic.
`timescale 1ns/1ps
module tb_l1_dcache;
  import cache_types::*;

`ifdef DCACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  l1_dcache_cpu_if #(.ADDR_W(32)) cpu ();
  l1_dcache_mem_if #(.ADDR_W(32)) pmem ();

  l1_dcache #(.S_INDEX(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu      (cpu),
    .pmem     (pmem),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Backing memory (what the memory side holds) and architectural memory (what the CPU should see).
  logic [31:0] bmem [int unsigned];
  logic [31:0] rmem [int unsigned];

  function automatic logic [31:0] seed_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] bget(input int unsigned w);
    if (bmem.exists(w)) return bmem[w];
    return seed_word(w);
  endfunction

  function automatic logic [31:0] rget(input int unsigned w);
    if (rmem.exists(w)) return rmem[w];
    return bget(w);
  endfunction

  // Which line each set should hold, and whether it carries unwritten-back data.
  logic [22:0] mtag   [16];
  bit          mval   [16];
  bit          mdirty [16];
  int          m_hits, m_misses;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      if (mval[i] && mdirty[i]) begin
        for (int k = 0; k < 8; k++) begin
          int unsigned w;
          w = ((int'(mtag[i]) << 9) | (i << 5)) / 4 + k;
          rmem[w] = bget(w);
        end
      end
      mval[i]   = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  // Memory model: random response delay, logs every completed transfer as {is_write, addr}.
  logic [32:0] ev_q [$];
  bit          mem_hold   = 1'b0;
  int          inject_cnt = 0;

  initial begin
    int mem_wait;
    int inject_seen;
    int unsigned base;
    mem_wait    = -1;
    inject_seen = 0;
    pmem.pmem_resp  = 1'b0;
    pmem.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem.pmem_resp = 1'b0;
      if (!reset_n) begin
        mem_wait = -1;
      end else if (pmem.pmem_read || pmem.pmem_write) begin
        check("pmem_exclusive", {63'b0, pmem.pmem_read & pmem.pmem_write}, 64'd0);
        check("pmem_align", {59'b0, pmem.pmem_addr[4:0]}, 64'd0);
        if (!mem_hold) begin
          if (mem_wait < 0) mem_wait = int'($urandom_range(3, 0));
          if (mem_wait == 0) begin
            mem_wait = -1;
            base = pmem.pmem_addr >> 2;
            if (pmem.pmem_write) begin
              for (int i = 0; i < 8; i++) bmem[base + i] = pmem.pmem_wdata[32*i +: 32];
              ev_q.push_back({1'b1, pmem.pmem_addr});
            end else begin
              for (int i = 0; i < 8; i++) pmem.pmem_rdata[32*i +: 32] = bget(base + i);
              ev_q.push_back({1'b0, pmem.pmem_addr});
            end
            pmem.pmem_resp = 1'b1;
          end else begin
            mem_wait--;
          end
        end
      end else if (inject_cnt != inject_seen) begin
        inject_seen     = inject_cnt;
        pmem.pmem_rdata = {8{32'hBADC0DE5}};
        pmem.pmem_resp  = 1'b1;
      end
    end
  end

  task automatic do_reset();
    cpu.cpu_read  = 1'b0;
    cpu.cpu_write = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_cpu_resp",   {63'b0, cpu.cpu_resp}, 64'd0);
    check("rst_cpu_rdata",  {32'b0, cpu.cpu_rdata}, 64'd0);
    check("rst_pmem_read",  {63'b0, pmem.pmem_read}, 64'd0);
    check("rst_pmem_write", {63'b0, pmem.pmem_write}, 64'd0);
    check("rst_pmem_addr",  {32'b0, pmem.pmem_addr}, 64'd0);
    check("rst_pmem_wdata", {63'b0, |pmem.pmem_wdata}, 64'd0);
    check("rst_hit_cnt",    {32'b0, hit_cnt}, 64'd0);
    check("rst_miss_cnt",   {32'b0, miss_cnt}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic xact(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] wm, output logic [31:0] rdata);
    int unsigned idx;
    int unsigned w;
    logic [22:0] tag;
    bit          hit, evict;
    int          cyc;
    logic [31:0] nv;
    idx   = addr[8:5];
    w     = addr >> 2;
    tag   = addr[31:9];
    hit   = mval[idx] && (mtag[idx] == tag);
    evict = !hit && mval[idx] && mdirty[idx];
    cyc   = 0;
    ev_q.delete();
    cpu.cpu_read  = rd;
    cpu.cpu_write = wr;
    cpu.cpu_addr  = addr;
    cpu.cpu_wdata = wd;
    cpu.cpu_wmask = wm;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu.cpu_resp && cyc < 200);
    rdata = cpu.cpu_rdata;
    check("resp_seen", {63'b0, cpu.cpu_resp}, 64'd1);
    cpu.cpu_read  = 1'b0;
    cpu.cpu_write = 1'b0;
    if (hit) begin
      m_hits++;
      check("hit_latency", 64'(cyc), 64'd1);
      check("hit_no_pmem", 64'(ev_q.size()), 64'd0);
    end else begin
      m_misses++;
      check("miss_pmem_ops", 64'(ev_q.size()), evict ? 64'd2 : 64'd1);
      if (evict && ev_q.size() == 2) begin
        check("wb_op",   64'(ev_q[0]), {31'b0, 1'b1, mtag[idx], idx[3:0], 5'b0});
        check("fill_op", 64'(ev_q[1]), {31'b0, 1'b0, addr[31:5], 5'b0});
      end else if (!evict && ev_q.size() == 1) begin
        check("fill_op", 64'(ev_q[0]), {31'b0, 1'b0, addr[31:5], 5'b0});
      end
      mtag[idx]   = tag;
      mval[idx]   = 1'b1;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      nv = rget(w);
      for (int b = 0; b < 4; b++) if (wm[b]) nv[8*b +: 8] = wd[8*b +: 8];
      rmem[w] = nv;
      if (wm != 4'b0000) mdirty[idx] = 1'b1;
    end else begin
      check("rdata", {32'b0, rdata}, {32'b0, rget(w)});
    end
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          seen;
    cpu.cpu_read  = 1'b0;
    cpu.cpu_write = 1'b0;
    cpu.cpu_wmask = '0;
    cpu.cpu_addr  = '0;
    cpu.cpu_wdata = '0;
    bmem[32'h40 >> 2] = 32'hDEADBEEF;
    bmem[32'h44 >> 2] = 32'hAAAAAAAA;
    do_reset();

    // Cold read fills the line, then re-read hits.
    xact(1, 0, 32'h40, 0, 0, rd);
    check("t1_fill_word0", {32'b0, rd}, 64'hDEADBEEF);
    xact(1, 0, 32'h40, 0, 0, rd);
    check("t1_hit_word0", {32'b0, rd}, 64'hDEADBEEF);

    // Stray memory response while idle must change nothing.
    inject_cnt++;
    repeat (3) @(negedge clk);
    check("t5_cpu_resp",   {63'b0, cpu.cpu_resp}, 64'd0);
    check("t5_pmem_read",  {63'b0, pmem.pmem_read}, 64'd0);
    check("t5_pmem_write", {63'b0, pmem.pmem_write}, 64'd0);
    check("t5_pmem_addr",  {32'b0, pmem.pmem_addr}, 64'd0);
    xact(1, 0, 32'h40, 0, 0, rd);
    check("t5_line_intact", {32'b0, rd}, 64'hDEADBEEF);

    // Partial write hit, then read back merged word.
    xact(0, 1, 32'h44, 32'h11223344, 4'b0011, rd);
    xact(1, 0, 32'h44, 0, 0, rd);
    check("t2_merge", {32'b0, rd}, 64'hAAAA3344);

    // Conflicting line forces writeback of the dirty one.
    xact(1, 0, 32'h240, 0, 0, rd);
    check("t3_wb_word1", {32'b0, bget(32'h44 >> 2)}, 64'hAAAA3344);

    // Reset during a fill abandons it; the line must miss again later.
    mem_hold = 1'b1;
    cpu.cpu_addr = 32'h80;
    cpu.cpu_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = pmem.pmem_read;
    end
    check("t4_fetch_issued", {63'b0, seen}, 64'd1);
    check("t4_fetch_addr", {32'b0, pmem.pmem_addr}, 64'h80);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_read_drop", {63'b0, pmem.pmem_read}, 64'd0);
    check("t4_addr_drop", {32'b0, pmem.pmem_addr}, 64'd0);
    cpu.cpu_read = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    model_reset();
    mem_hold = 1'b0;
    @(negedge clk);
    xact(1, 0, 32'h80, 0, 0, rd);

    // Two misses then three hits.
    do_reset();
    xact(1, 0, 32'h00, 0, 0, rd);
    xact(1, 0, 32'h20, 0, 0, rd);
    xact(1, 0, 32'h00, 0, 0, rd);
    xact(1, 0, 32'h04, 0, 0, rd);
    xact(1, 0, 32'h20, 0, 0, rd);
    check("t6_miss_cnt", {32'b0, miss_cnt}, PERF ? 64'd2 : 64'd0);
    check("t6_hit_cnt",  {32'b0, hit_cnt},  PERF ? 64'd3 : 64'd0);

    // Random traffic over a few tags and sets to provoke conflicts and evictions.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      bit          wr, rdf;
      a   = ($urandom_range(3, 0) << 9) | ($urandom_range(3, 0) << 5) |
            ($urandom_range(7, 0) << 2) | $urandom_range(3, 0);
      wr  = ($urandom_range(9, 0) < 4);
      rdf = wr ? ($urandom_range(3, 0) == 0) : 1'b1;
      xact(rdf, wr, a, $urandom, 4'($urandom_range(15, 0)), rd);
    end
    check("end_hit_cnt",  {32'b0, hit_cnt},  PERF ? 64'(m_hits)   : 64'd0);
    check("end_miss_cnt", {32'b0, miss_cnt}, PERF ? 64'(m_misses) : 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
